data_bus_sequencer: RTL

Sequences single-source, multi-destination transfers on the 8-bit relay-computer data bus. It accepts a transfer request (one source, a mask of destinations) and drives the per-register bus drive and load enables through a break-before-make relay sequence: select, settle, load, hold, release. Bus contention is impossible by construction because at most one drive enable is asserted at any time. It sits between the instruction sequencer and the register/memory modules on the data bus.

---
 rtl/data_bus_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_bus_sequencer.sv
// data_bus_sequencer
//   Break-before-make sequencer for the relay-computer data bus. A request
//   names one source and a mask of destinations; the block walks
//   IDLE -> SELECT -> LOAD -> HOLD -> RELEASE -> IDLE, driving one source
//   enable and pulsing the destination load enables in the middle of the
//   drive window. Bad requests take IDLE -> ERROR -> IDLE with an err pulse.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   req_valid/     request handshake; accepted when both high on an edge
//   req_ready
//   req_src        source code 0..8 (A,B,C,D,M1,M2,X,Y,MEM); 9..15 invalid
//   req_dst        13-bit destination mask (A..Y, J1, J2, INST, MEM, CCR)
//   bus_data       live bus value, sampled at the end of the last LOAD cycle
//   drive_en       one-hot source drive enable (bit = source code)
//   load_en        destination load enables (same order as req_dst)
//   xfer_data      last captured bus value
//   done / err     one-cycle completion / rejection pulses
module data_bus_sequencer #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int LOAD_CYCLES    = 1,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_src,
  input  logic [12:0]               req_dst,
  input  logic [DATA_BUS_WIDTH-1:0] bus_data,
  output logic [8:0]                drive_en,
  output logic [12:0]               load_en,
  output logic [DATA_BUS_WIDTH-1:0] xfer_data,
  output logic                      done,
  output logic                      err
);

  localparam int MAXP = (SETTLE_CYCLES > LOAD_CYCLES)
                      ? ((SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES)
                      : ((LOAD_CYCLES > HOLD_CYCLES) ? LOAD_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SETTLE_RL = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_RL   = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_RL   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, LOAD, HOLD, RELEASE, ERROR
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  logic [3:0]                r_src;
  logic [12:0]               r_dst;
  logic [DATA_BUS_WIDTH-1:0] r_xfer;
  logic                      w_accept, w_capture, w_reject;
  logic [12:0]               w_self;

  // Destination bit that aliases the source's own register. MEM is source 8
  // but destination bit 11, so it needs its own case.
  always_comb begin
    w_self = '0;
    if (req_src < 4'd8)       w_self = 13'd1 << req_src;
    else if (req_src == 4'd8) w_self = 13'h0800;
  end

  assign w_reject = (req_src > 4'd8) || (req_dst == '0) || ((req_dst & w_self) != '0);

  // Next state: each timed phase reloads the shared down-counter with
  // (length - 1) on entry and leaves when it reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_accept = 1'b1;
        if (w_reject) w_state_nxt = ERROR;
        else begin
          w_state_nxt = SELECT;
          w_cnt_nxt   = SETTLE_RL;
        end
      end
      SELECT: if (r_cnt == '0) begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = LOAD_RL;
      end else w_cnt_nxt = r_cnt - 1'b1;
      LOAD: if (r_cnt == '0) begin
        w_capture   = 1'b1;
        w_state_nxt = HOLD;
        w_cnt_nxt   = HOLD_RL;
      end else w_cnt_nxt = r_cnt - 1'b1;
      HOLD: if (r_cnt == '0) w_state_nxt = RELEASE;
            else w_cnt_nxt = r_cnt - 1'b1;
      RELEASE: w_state_nxt = IDLE;
      ERROR:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_xfer  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_src <= req_src;
        r_dst <= req_dst;
      end
      if (w_capture) r_xfer <= bus_data;
    end
  end

  // Outputs depend only on state and latched request, so req_* never reaches
  // the enables combinationally. drive_en is a shift of a single bit, which
  // keeps it one-hot; it is only enabled in the three drive phases.
  always_comb begin
    drive_en  = '0;
    load_en   = '0;
    if (r_state == SELECT || r_state == LOAD || r_state == HOLD)
      drive_en = 9'd1 << r_src;
    if (r_state == LOAD) load_en = r_dst;
    done      = (r_state == RELEASE);
    err       = (r_state == ERROR);
    req_ready = (r_state == IDLE);
    xfer_data = r_xfer;
  end

endmodule
